// File: rtl/regfile_dump_reader.sv
// Walks registers FIRST_REG..LAST_REG through a spare register-file read port
// and streams each value with its index over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int unsigned FIRST_REG = 1,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    if (FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
        $error("regfile_dump_reader: need FIRST_REG <= LAST_REG <= 31");
    end

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        FIN
    } state_t;

    state_t      state_q;
    logic [4:0]  rd_addr_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic [4:0]  out_addr_q;
    logic        out_last_q;
    logic        busy_q;
    logic        done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // abort outranks start and out_ready; it drops any pending word
            if (abort && state_q != IDLE) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            rd_addr_q <= FIRST_A;
                            busy_q    <= 1'b1;
                            state_q   <= FETCH;
                        end
                    end
                    FETCH: begin
                        out_data_q  <= rd_data;
                        out_addr_q  <= rd_addr_q;
                        out_last_q  <= (rd_addr_q == LAST_A);
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (out_last_q) begin
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end else begin
                                rd_addr_q <= rd_addr_q + 5'd1;
                                state_q   <= FETCH;
                            end
                        end
                    end
                    FIN: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential reader that walks a range of architectural registers through a spare register-file read port and streams each word, with its register number, to a downstream consumer over a valid/ready handshake. It sits beside the register file in the pipelined CPU. It feeds debug sinks such as the display driver or a serial transmitter, replacing single-register hard-wired taps with a full scan. It never writes the register file.

## Interface
- FIRST_REG, 1, first register index scanned (0..31)
- LAST_REG, 31, last register index scanned (FIRST_REG..31)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  scan request, sampled every edge; honoured only in IDLE
- abort  in  1  synchronous cancel of a scan in progress
- rd_addr  out  5  register-file read address
- rd_data  in  32  register-file read data, combinational from rd_addr (index 0 reads 0)
- out_valid  out  1  out_data/out_addr/out_last valid
- out_ready  in  1  consumer accepts the word when high with out_valid
- out_data  out  32  captured register value
- out_addr  out  5  register index of out_data
- out_last  out  1  high with the word for LAST_REG
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final word is accepted

## Operation
- States: IDLE, FETCH, SEND, FIN.
- IDLE: out_valid=0. If start=1 and abort=0: rd_addr<=FIRST_REG, go FETCH. Otherwise stay.
- FETCH: lasts exactly one cycle. rd_addr is stable for the whole cycle. At the closing edge:
  - out_data<=rd_data, out_addr<=rd_addr, out_last<=(rd_addr==LAST_REG), out_valid<=1
  - go SEND
- SEND: out_data, out_addr and out_last are held stable while out_valid=1 and out_ready=0. On an edge with out_ready=1:
  - out_valid<=0
  - if out_last: go FIN
  - else: rd_addr<=rd_addr+1, go FETCH
- FIN: done=1 for this cycle only, then go IDLE.
- abort=1 in FETCH, SEND or FIN: next edge goes to IDLE with out_valid<=0, done stays 0, and any pending word is dropped. abort in IDLE has no effect. abort wins over start and over out_ready on the same edge.
- start while busy is ignored and not queued.
- Register-file writes during a scan: the value delivered is whatever rd_data shows during that register's FETCH cycle. A write landing on the same edge is not reflected.
- rd_addr holds its last value in IDLE. Index arithmetic is 5-bit. The increment never wraps, because the scan terminates at LAST_REG ≤ 31.
- Parameter legality: FIRST_REG ≤ LAST_REG ≤ 31. Violation is a compile-time error.

## Timing
- Reset values: rd_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-scan clears everything immediately and asynchronously. There is no done pulse.
- Edge n samples start=1. busy is high from after edge n. The FETCH cycle is n..n+1. out_valid rises after edge n+1.
- With out_ready held high, each word takes 2 cycles (FETCH + SEND). N = LAST_REG−FIRST_REG+1 words. done is high 2N cycles after the start edge, for one cycle. busy falls together with done's deassertion.
- Each extra cycle with out_ready=0 in SEND adds exactly one cycle. Data must not change while stalled.
- A new start is accepted on the edge where the state is IDLE, i.e. one cycle after the done pulse at the earliest.

## Test plan
- Full scan, default params, registers preloaded r[i]=0x100+i, out_ready=1 → 31 words, out_addr 1..31, out_data 0x101..0x11F, out_last only on addr 31, done exactly 62 cycles after start, busy low afterwards.
- Backpressure: out_ready toggled pseudo-randomly → same 31 words in order, no duplicates or drops, out_data/out_addr stable while stalled, done delayed by exactly the number of stall cycles.
- FIRST_REG=LAST_REG=14, r14=0xDEADBEEF → one word, addr 14, out_last=1, done 2 cycles after start; FIRST_REG=0 → first word addr 0, data 0.
- Abort after word 5 is accepted (and abort while SEND is stalled) → out_valid low after next edge, no done, busy low; subsequent start rescans from FIRST_REG.
- start pulsed again mid-scan → ignored, sequence unchanged; start and abort together in IDLE → stays IDLE.
- Async reset mid-SEND (between edges) → all outputs 0 immediately; write r3 during its FETCH edge → delivered value is the pre-write value.
